spi_tsense_poller: RTL and testbench
====================================

# spi_tsense_poller

Parametrised SPI read master that polls up to NCH serial temperature sensors (LM07-class, read-only, MSB first) sharing one SCK/SIO pair, each with its own active-low chip select. It generates CS and SCK from the system clock with a programmable divider and captures a DATA_W-bit word per frame. It presents each word with its channel index and a one-cycle VALID strobe. It supports continuous round-robin polling and single-shot sweeps, and sits between the sensor pins and the display/register logic.

## Interface
- DATA_W, 8: bits captured per frame, legal 8..16.
- NCH, 4: number of sensor channels, legal 1..8.
- CLK_DIV, 2: SCK half-period in SYSCLK cycles, legal 1..15.
- GAP, 4: SYSCLK cycles with all CS high between frames, legal 1..31.
- SYSCLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- CONT  in  1  1 = continuous round-robin; 0 = single-shot mode.
- START  in  1  single-shot trigger pulse; ignored when CONT=1 or BUSY=1.
- CH_EN  in  NCH  per-channel enable mask.
- SIO  in  1  shared serial data from sensors.
- CS  out  NCH  active-low chip selects; at most one bit low.
- SCK  out  1  SPI clock, idle low.
- DATA  out  DATA_W  last captured word.
- CH  out  max(1,$clog2(NCH))  channel index of DATA.
- VALID  out  1  one-cycle pulse when DATA/CH update.
- BUSY  out  1  high while a frame or single-shot sweep is in progress.

## Operation
- Reset values: CS all 1, SCK 0, DATA 0, CH 0, VALID 0, BUSY 0, FSM IDLE, channel pointer = NCH-1, so the first search starts at channel 0.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE → SETUP when a channel is selected:
  - CONT=1, or a START was accepted, and
  - CH_EN has at least one bit set.
- If CH_EN is all zero, the block stays in IDLE with BUSY=0; a START accepted with an all-zero mask is dropped.
- Channel selection: the next enabled channel strictly after the pointer, ascending, wrapping NCH-1→0. With a single enabled channel, that channel is re-selected.
- CH_EN is sampled only at selection; changing it mid-frame does not abort the frame.
- SETUP: the selected CS bit is low, SCK=0, for CLK_DIV cycles.
- SHIFT: DATA_W bit periods. Each period is CLK_DIV cycles SCK low, then CLK_DIV cycles SCK high.
- SIO is sampled into the shift register MSB-first on the SYSCLK edge that drives SCK 0→1. The sensor updates on SCK falling edges.
- HOLD: SCK=0 with CS still low for CLK_DIV cycles.
- On the HOLD exit edge, all of the following happen together:
  - CS goes all high;
  - DATA ← shift register, CH ← channel;
  - VALID=1 for exactly one cycle;
  - FSM → GAP.
- GAP: GAP cycles, then:
  - CONT=1 → select the next channel and go to SETUP.
  - Single-shot → if the next enabled channel index is greater than the one just read, continue the sweep. Otherwise the sweep is done: BUSY=0, IDLE.
- A single-shot sweep reads every enabled channel once, in ascending index order.
- CONT dropping to 0 mid-frame: the current frame completes normally (VALID issued), then the block goes IDLE.
- RST mid-frame: next cycle CS all high, SCK 0, no VALID; the partial word is discarded and DATA keeps 0.
- START and CONT=1 together: CONT takes precedence.

## Timing
- Frame length is FRAME = 2·CLK_DIV + 2·CLK_DIV·DATA_W SYSCLK cycles with CS low, then GAP cycles with all CS high.
- Defaults give a frame of 36 cycles CS low plus 4 GAP, so one word every 40 cycles per active channel.
- SCK: exactly DATA_W rising edges per frame, 50% duty, none while CS is high.
- Capture latency: VALID rises on the same edge that CS rises, i.e. FRAME cycles after CS falls.
- BUSY rises on the edge that CS falls for the first frame. It falls on the last GAP edge of a single-shot sweep, and stays high while CONT=1 with a non-empty mask.

## Test plan
- Reset, defaults, CONT=1, CH_EN=4'b1111, each sensor model returns 8'hA5, 8'h3C, 8'h00, 8'hFF → VALID pulses every 40 cycles, CH 0,1,2,3,0…, DATA matches, each CS low 36 cycles, 8 SCK rises per frame.
- CONT=0, CH_EN=4'b1010, one START pulse → exactly two frames (CH=1, then CH=3), then BUSY=0 and CS all high; a second START issued during the sweep is ignored.
- DATA_W=13, CLK_DIV=1, NCH=1, sensor returns 13'h1ABC → DATA=13'h1ABC, CS low 28 cycles, VALID once per 32 cycles.
- Assert RST for one cycle at SCK rise 5 of a frame → CS all high and SCK 0 next cycle, no VALID, DATA=0; polling restarts at CH=0.
- CH_EN changed from 4'b0001 to 4'b0100 mid-frame → current CH=0 frame completes with VALID; the next frame selects CH=2.
- CH_EN=0 with CONT=1 → no CS activity and BUSY=0 for 200 cycles; setting CH_EN=4'b1000 → first frame on CH=3.

Source files
------------

// File: rtl/spi_tsense_poller.sv
// spi_tsense_poller
// SPI read master polling up to NCH read-only serial temperature sensors that
// share one SCK/SIO pair, each sensor having its own active-low chip select.
// One DATA_W-bit word is captured MSB-first per frame and presented with its
// channel index and a one-cycle VALID strobe.
//
// Ports:
//   SYSCLK  system clock, rising edge
//   RST     synchronous active-high reset
//   CONT    1 = continuous round-robin polling, 0 = single-shot mode
//   START   single-shot sweep trigger (ignored while CONT=1 or BUSY=1)
//   CH_EN   per-channel enable mask, sampled when a channel is selected
//   SIO     shared serial data from the sensors
//   CS      active-low chip selects, at most one low
//   SCK     SPI clock, idle low
//   DATA    last captured word
//   CH      channel index of DATA
//   VALID   one-cycle pulse when DATA/CH update
//   BUSY    high during a frame or a single-shot sweep
module spi_tsense_poller #(
  parameter int  DATA_W  = 8,
  parameter int  NCH     = 4,
  parameter int  CLK_DIV = 2,
  parameter int  GAP     = 4,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic              CONT,
  input  logic              START,
  input  logic [NCH-1:0]    CH_EN,
  input  logic              SIO,
  output logic [NCH-1:0]    CS,
  output logic              SCK,
  output logic [DATA_W-1:0] DATA,
  output logic [CW-1:0]     CH,
  output logic              VALID,
  output logic              BUSY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [4:0] DIV_LAST = 5'(CLK_DIV - 1);
  localparam logic [4:0] GAP_LAST = 5'(GAP - 1);
  localparam logic [4:0] BIT_LAST = 5'(DATA_W - 1);

  logic [2:0]        state;
  logic [4:0]        cnt;
  logic [4:0]        bitn;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     ptr;
  logic              sweep;

  logic [CW-1:0]     base;
  logic [CW-1:0]     nxt;
  logic [CW:0]       sum;
  logic              found;
  logic [NCH-1:0]    sel_onehot;
  logic              go_on;

  // Next enabled channel strictly after base, wrapping. A single-shot sweep
  // searches from NCH-1 so it always begins at the lowest enabled channel.
  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    base  = (state == S_IDLE && !CONT) ? CW'(NCH - 1) : ptr;
    nxt   = base;
    found = 1'b0;
    sum   = '0;
    for (int unsigned k = NCH; k >= 1; k--) begin
      sum = {1'b0, base} + (CW+1)'(k);
      if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
      if (CH_EN[sum[CW-1:0]]) begin
        nxt   = sum[CW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[nxt] = 1'b1;
  end

  // Continue after GAP: always in continuous mode, otherwise only while the
  // single-shot sweep still has a higher-indexed channel to read.
  always_comb begin
    go_on = found && (CONT || (sweep && (nxt > ptr)));
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      ptr   <= CW'(NCH - 1);
      sweep <= 1'b0;
      CS    <= '1;
      SCK   <= 1'b0;
      DATA  <= '0;
      CH    <= '0;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((CONT || START) && found) begin
            ptr   <= nxt;
            CS    <= ~sel_onehot;
            cnt   <= '0;
            sweep <= !CONT;
            BUSY  <= 1'b1;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!SCK) begin
              SCK   <= 1'b1;
              shreg <= {shreg[DATA_W-2:0], SIO};
            end else begin
              SCK <= 1'b0;
              if (bitn == BIT_LAST) state <= S_HOLD;
              else                  bitn  <= bitn + 5'd1;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            CS    <= '1;
            DATA  <= shreg;
            CH    <= ptr;
            VALID <= 1'b1;
            state <= S_GAP;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (go_on) begin
              ptr   <= nxt;
              CS    <= ~sel_onehot;
              sweep <= !CONT;
              state <= S_SETUP;
            end else begin
              sweep <= 1'b0;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          CS    <= '1;
          SCK   <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tsense_poller.sv
// Self-checking bench for spi_tsense_poller: default-parameter instance with a
// four-sensor pin model, plus a DATA_W=13 / CLK_DIV=1 / NCH=1 instance.
module tb_spi_tsense_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance 1: defaults ----------------
  logic       rst = 1'b1, cont = 1'b0, start = 1'b0, sio = 1'b0;
  logic [3:0] ch_en = '0;
  logic [3:0] cs;
  logic       sck, valid, busy;
  logic [7:0] data;
  logic [1:0] ch;

  spi_tsense_poller #(.DATA_W(8), .NCH(4), .CLK_DIV(2), .GAP(4)) dut (
    .SYSCLK(clk), .RST(rst), .CONT(cont), .START(start), .CH_EN(ch_en),
    .SIO(sio), .CS(cs), .SCK(sck), .DATA(data), .CH(ch), .VALID(valid),
    .BUSY(busy)
  );

  // ---------------- instance 2: 13-bit, single channel ----------------
  logic        rst2 = 1'b1, cont2 = 1'b0, start2 = 1'b0, sio2 = 1'b0;
  logic [0:0]  ch_en2 = 1'b0;
  logic [0:0]  cs2, ch2;
  logic        sck2, valid2, busy2;
  logic [12:0] data2;

  spi_tsense_poller #(.DATA_W(13), .NCH(1), .CLK_DIV(1), .GAP(4)) dut2 (
    .SYSCLK(clk), .RST(rst2), .CONT(cont2), .START(start2), .CH_EN(ch_en2),
    .SIO(sio2), .CS(cs2), .SCK(sck2), .DATA(data2), .CH(ch2), .VALID(valid2),
    .BUSY(busy2)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- sensor models + monitors ----------------
  logic [7:0]  sw [4];
  logic [12:0] w2 = 13'h1ABC;

  int   cyc = 0, len = 0, rises = 0, falls = 0, multi_low = 0;
  logic psck = 1'b0, pall = 1'b1;
  int   vq_ch[$], vq_data[$], vq_cyc[$], fq_len[$], fq_rise[$];

  always @(negedge clk) begin
    cyc++;
    if (&cs) begin
      if (!pall) begin fq_len.push_back(len); fq_rise.push_back(rises); end
      len = 0; rises = 0; falls = 0;
    end else begin
      len++;
      if (sck && !psck) rises++;
      if (psck && !sck) falls++;
    end
    if ($countones(~cs) > 1) multi_low++;
    if (valid) begin
      vq_ch.push_back(int'(ch)); vq_data.push_back(int'(data)); vq_cyc.push_back(cyc);
    end
    // Selected sensor presents MSB at CS fall and shifts on each SCK fall.
    sio = 1'b0;
    for (int i = 0; i < 4; i++)
      if (!cs[i] && falls < 8) sio = sw[i][7-falls];
    psck = sck; pall = &cs;
  end

  int   cyc2 = 0, len2 = 0, r2 = 0, fall2 = 0;
  logic psck2 = 1'b0, pall2 = 1'b1;
  int   v2d[$], v2c[$], v2ch[$], f2len[$], f2rise[$];

  always @(negedge clk) begin
    cyc2++;
    if (cs2[0]) begin
      if (!pall2) begin f2len.push_back(len2); f2rise.push_back(r2); end
      len2 = 0; r2 = 0; fall2 = 0;
    end else begin
      len2++;
      if (sck2 && !psck2) r2++;
      if (psck2 && !sck2) fall2++;
    end
    if (valid2) begin
      v2d.push_back(int'(data2)); v2c.push_back(cyc2); v2ch.push_back(int'(ch2));
    end
    sio2 = (!cs2[0] && fall2 < 13) ? w2[12-fall2] : 1'b0;
    psck2 = sck2; pall2 = cs2[0];
  end

  // ---------------- reference model ----------------
  // Expected channel order: enabled channels ascending, cycling.
  int exp_q[$];
  task automatic build_list(input logic [3:0] m, input int n);
    int lst[$];
    for (int i = 0; i < 4; i++) if (m[i]) lst.push_back(i);
    exp_q.delete();
    if (n < 0) n = lst.size();
    if (lst.size() > 0)
      for (int j = 0; j < n; j++) exp_q.push_back(lst[j % lst.size()]);
  endtask

  task automatic clear_q();
    vq_ch.delete(); vq_data.delete(); vq_cyc.delete(); fq_len.delete(); fq_rise.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; cont = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic wait_valid(input int n, input int budget);
    int t = 0;
    while (vq_ch.size() < n && t < budget) begin @(negedge clk); t++; end
    chk("valid count", vq_ch.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin @(negedge clk); t++; end
    chk("busy low", busy, 0);
  endtask

  task automatic check_exp(input string tag);
    chk({tag, " frames"}, vq_ch.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < vq_ch.size(); i++) begin
      chk({tag, " ch"}, vq_ch[i], exp_q[i]);
      chk({tag, " data"}, vq_data[i], int'(sw[exp_q[i]]));
    end
    for (int i = 0; i < fq_len.size(); i++) begin
      chk({tag, " cs low len"}, fq_len[i], 36);
      chk({tag, " sck rises"}, fq_rise[i], 8);
    end
  endtask

  task automatic run_sweep(input logic [3:0] en);
    int t = 0;
    ch_en = en;
    clear_q();
    start = 1'b1; @(negedge clk); start = 1'b0;
    if (en == 4'b0000) begin
      chk("empty start busy", busy, 0);
      repeat (60) @(negedge clk);
      chk("empty start busy later", busy, 0);
    end else begin
      chk("sweep busy", busy, 1);
      while (busy && t < 1000) begin
        if (t == 30) start = 1'b1;   // second START mid-sweep must be ignored
        @(negedge clk);
        start = 1'b0;
        t++;
      end
      chk("sweep done", busy, 0);
      repeat (60) @(negedge clk);
    end
    chk("sweep cs idle", cs, 4'hF);
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [31:0] words;
    int          nfr;
    logic [7:0]  chs;   // expected channel k at [2k+:2]
  } sweep_vec_t;

  sweep_vec_t tbl [6];

  initial begin
    logic [3:0] m;
    int n, t;
    logic p;

    tbl[0] = '{en: 4'b1010, words: 32'hFF003CA5, nfr: 2, chs: 8'h0D};
    tbl[1] = '{en: 4'b0001, words: 32'h11223344, nfr: 1, chs: 8'h00};
    tbl[2] = '{en: 4'b1111, words: 32'h80017EC3, nfr: 4, chs: 8'hE4};
    tbl[3] = '{en: 4'b0000, words: 32'h55AA55AA, nfr: 0, chs: 8'h00};
    tbl[4] = '{en: 4'b0110, words: 32'h0F1E2D3C, nfr: 2, chs: 8'h09};
    tbl[5] = '{en: 4'b1000, words: 32'hDEADBEEF, nfr: 1, chs: 8'h03};

    // ---- reset state ----
    do_reset();
    chk("reset cs", cs, 4'hF);
    chk("reset sck", sck, 0);
    chk("reset data", data, 0);
    chk("reset ch", ch, 0);
    chk("reset valid", valid, 0);
    chk("reset busy", busy, 0);

    // ---- continuous round-robin ----
    sw[0] = 8'hA5; sw[1] = 8'h3C; sw[2] = 8'h00; sw[3] = 8'hFF;
    ch_en = 4'b1111; cont = 1'b1;
    p = busy; t = 0;
    while (&cs && t < 50) begin p = busy; @(negedge clk); t++; end
    chk("busy before first cs fall", p, 0);
    chk("busy at first cs fall", busy, 1);
    wait_valid(9, 500);
    build_list(4'b1111, 9);
    check_exp("cont");
    for (int i = 1; i < vq_cyc.size(); i++) chk("cont period", vq_cyc[i] - vq_cyc[i-1], 40);
    repeat (10) @(negedge clk);   // mid-frame of the tenth word
    cont = 1'b0;
    wait_idle(100);
    chk("cont drop final frame", vq_ch.size(), 10);
    repeat (60) @(negedge clk);
    chk("cont drop no more frames", vq_ch.size(), 10);
    chk("cont drop cs idle", cs, 4'hF);

    // ---- single-shot sweeps from table ----
    do_reset();
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) sw[i] = tbl[v].words[8*i +: 8];
      exp_q.delete();
      for (int k = 0; k < tbl[v].nfr; k++) exp_q.push_back(int'(tbl[v].chs[2*k +: 2]));
      run_sweep(tbl[v].en);
      check_exp("sweep tbl");
    end

    // ---- randomized single-shot sweeps ----
    for (int r = 0; r < 6; r++) begin
      m = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) sw[i] = 8'($urandom);
      build_list(m, -1);
      run_sweep(m);
      check_exp("sweep rnd");
    end

    // ---- randomized continuous runs ----
    for (int r = 0; r < 3; r++) begin
      do_reset();
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) sw[i] = 8'($urandom);
      ch_en = m; cont = 1'b1;
      wait_valid(6, 400);
      build_list(m, 6);
      check_exp("cont rnd");
      cont = 1'b0;
      wait_idle(100);
    end

    // ---- reset at SCK rise 5 ----
    do_reset();
    sw[0] = 8'h96; ch_en = 4'b1111; cont = 1'b1;
    n = 0; t = 0; p = 1'b0;
    while (n < 5 && t < 300) begin
      @(negedge clk); t++;
      if (sck && !p) n++;
      p = sck;
    end
    chk("rst at rise 5 reached", n, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid cs", cs, 4'hF);
    chk("rst mid sck", sck, 0);
    chk("rst mid valid", valid, 0);
    chk("rst mid data", data, 0);
    chk("rst mid busy", busy, 0);
    chk("rst mid no valid", vq_ch.size(), 0);
    rst = 1'b0;
    clear_q();
    wait_valid(1, 100);
    if (vq_ch.size() > 0) begin
      chk("rst restart ch", vq_ch[0], 0);
      chk("rst restart data", vq_data[0], 8'h96);
    end
    cont = 1'b0;
    wait_idle(100);

    // ---- CH_EN change mid-frame ----
    do_reset();
    sw[0] = 8'h5A; sw[2] = 8'hC7;
    ch_en = 4'b0001; cont = 1'b1;
    t = 0;
    while (&cs && t < 50) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    ch_en = 4'b0100;
    wait_valid(2, 200);
    if (vq_ch.size() >= 2) begin
      chk("mask change first ch", vq_ch[0], 0);
      chk("mask change first data", vq_data[0], 8'h5A);
      chk("mask change next ch", vq_ch[1], 2);
      chk("mask change next data", vq_data[1], 8'hC7);
    end
    cont = 1'b0;
    wait_idle(100);

    // ---- empty mask in continuous mode ----
    do_reset();
    sw[3] = 8'h3E;
    ch_en = 4'b0000; cont = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cs != 4'hF || busy) n++;
    end
    chk("empty mask activity", n, 0);
    ch_en = 4'b1000;
    wait_valid(1, 100);
    if (vq_ch.size() > 0) begin
      chk("mask 1000 ch", vq_ch[0], 3);
      chk("mask 1000 data", vq_data[0], 8'h3E);
    end
    cont = 1'b0;
    wait_idle(100);

    // ---- 13-bit single-channel instance ----
    rst2 = 1'b0; ch_en2 = 1'b1; cont2 = 1'b1;
    t = 0;
    while (v2d.size() < 3 && t < 300) begin @(negedge clk); t++; end
    chk("w13 valid count", v2d.size(), 3);
    for (int i = 0; i < v2d.size(); i++) begin
      chk("w13 data", v2d[i], 13'h1ABC);
      chk("w13 ch", v2ch[i], 0);
    end
    for (int i = 1; i < v2c.size(); i++) chk("w13 period", v2c[i] - v2c[i-1], 32);
    for (int i = 0; i < f2len.size(); i++) begin
      chk("w13 cs low len", f2len[i], 28);
      chk("w13 sck rises", f2rise[i], 13);
    end
    cont2 = 1'b0;

    chk("cs at most one low", multi_low, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
